// File: rtl/ip_codma_write_machine_pkg.sv
// ---------------------------------------------------------------------------
// ip_codma_pkg
// Shared types and constants for the CODMA write machine.
//   write_state_t   : write FSM state encoding (WR_IDLE must stay 0 so that a
//                     reset bus reads as all-zero)
//   SIZE_*          : legal transfer size codes
//   size_to_words() : size code -> number of 32-bit words, 0 for illegal codes
// ---------------------------------------------------------------------------
package ip_codma_pkg;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_ASK     = 2'd1,
        WR_GRANTED = 2'd2,
        WR_UNUSED  = 2'd3
    } write_state_t;

    localparam logic [3:0] SIZE_2W = 4'd3;
    localparam logic [3:0] SIZE_6W = 4'd8;
    localparam logic [3:0] SIZE_8W = 4'd9;

    // A zero return value marks the code as illegal.
    function automatic logic [3:0] size_to_words(input logic [3:0] size_code);
        logic [3:0] words;
        case (size_code)
            SIZE_2W: words = 4'd2;
            SIZE_6W: words = 4'd6;
            SIZE_8W: words = 4'd8;
            default: words = 4'd0;
        endcase
        return words;
    endfunction

endpackage

// File: rtl/ip_codma_write_machine_if.sv
// ---------------------------------------------------------------------------
// ip_codma_write_machine_if
// Memory-bus write port between the CODMA write machine and the bus fabric.
//   bus_req_o / bus_grant_i                      : arbitration
//   bus_write_o, bus_addr_o, bus_size_o          : transfer qualifiers
//   bus_write_data_o / _valid_o / _ready_i       : beat handshake
//   bus_error_i                                  : slave-reported error
// The _o/_i suffixes are from the write machine's point of view.
// Modports: master (write machine), slave (bus fabric / memory model).
// ---------------------------------------------------------------------------
interface ip_codma_write_machine_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) ();

    logic              bus_req_o;
    logic              bus_write_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [3:0]        bus_size_o;
    logic              bus_grant_i;
    logic [DATA_W-1:0] bus_write_data_o;
    logic              bus_write_valid_o;
    logic              bus_write_ready_i;
    logic              bus_error_i;

    modport master (
        output bus_req_o,
        output bus_write_o,
        output bus_addr_o,
        output bus_size_o,
        input  bus_grant_i,
        output bus_write_data_o,
        output bus_write_valid_o,
        input  bus_write_ready_i,
        input  bus_error_i
    );

    modport slave (
        input  bus_req_o,
        input  bus_write_o,
        input  bus_addr_o,
        input  bus_size_o,
        output bus_grant_i,
        input  bus_write_data_o,
        input  bus_write_valid_o,
        output bus_write_ready_i,
        output bus_error_i
    );

endinterface

// File: rtl/ip_codma_write_machine.sv
// ---------------------------------------------------------------------------
// ip_codma_write_machine
// Bus-master write engine of the CODMA datapath. On need_write_i it latches a
// destination address, size code and WORDS x 32-bit data register, requests
// the bus and, once granted, streams 64-bit beats {word[cnt+1], word[cnt]}
// under a valid/ready handshake until the size's word count is written.
//
// Ports
//   clk_i, reset_n_i     : clock, asynchronous active-low reset
//   need_write_i         : start request (only looked at in WR_IDLE)
//   stop_i               : abort back to WR_IDLE
//   dma_error_i          : controller error, aborts back to WR_IDLE
//   wr_addr_i, wr_size_i : destination address and size code (3, 8 or 9)
//   data_reg_i           : words to write, word 0 least significant
//   bus                  : master side of the memory-bus write port
//   wr_done_o            : one-cycle pulse after the last beat is accepted
//   wr_state_error_o     : high while sitting in WR_UNUSED (illegal size)
//   wr_state_r           : current state
//   wr_state_next_s      : combinational next state
// ---------------------------------------------------------------------------
module ip_codma_write_machine
    import ip_codma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int WORDS  = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  need_write_i,
    input  logic                  stop_i,
    input  logic                  dma_error_i,
    input  logic [ADDR_W-1:0]     wr_addr_i,
    input  logic [3:0]            wr_size_i,
    input  logic [WORDS*32-1:0]   data_reg_i,
    ip_codma_write_machine_if.master bus,
    output logic                  wr_done_o,
    output logic                  wr_state_error_o,
    output write_state_t          wr_state_r,
    output write_state_t          wr_state_next_s
);

    localparam int IDX_W = $clog2(WORDS);

    logic [ADDR_W-1:0]   addr_reg;
    logic [3:0]          size_reg;
    logic [WORDS*32-1:0] data_reg;
    logic [3:0]          cnt_reg;
    logic [3:0]          cnt_next;
    logic [DATA_W-1:0]   beat_next;

    logic [31:0]         word [WORDS];
    logic [3:0]          words_req;
    logic [3:0]          words_lat;
    logic                beat_accept;
    logic                last_beat;
    logic                any_error;
    logic                start_ok;
    logic [IDX_W-1:0]    lo_idx;
    logic [IDX_W-1:0]    hi_idx;

    // Split the latched data register into addressable 32-bit words.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign word[gi] = data_reg[gi*32 +: 32];
        end
    endgenerate

    assign words_req   = size_to_words(wr_size_i);
    assign words_lat   = size_to_words(size_reg);
    assign any_error   = bus.bus_error_i | dma_error_i;
    assign beat_accept = (wr_state_r == WR_GRANTED) && bus.bus_write_ready_i;
    assign last_beat   = beat_accept && ((cnt_reg + 4'd2) == words_lat);
    assign start_ok    = (wr_state_r == WR_IDLE) && (wr_state_next_s == WR_ASK);

    always_comb begin
        wr_state_next_s = wr_state_r;
        case (wr_state_r)
            WR_IDLE: begin
                if (need_write_i) begin
                    wr_state_next_s = (words_req != 4'd0) ? WR_ASK : WR_UNUSED;
                end
            end
            WR_ASK: begin
                if (bus.bus_grant_i) begin
                    wr_state_next_s = WR_GRANTED;
                end
            end
            WR_GRANTED: begin
                if (last_beat) begin
                    wr_state_next_s = WR_IDLE;
                end
            end
            WR_UNUSED: wr_state_next_s = WR_IDLE;
            default:   wr_state_next_s = WR_IDLE;
        endcase
        // Errors and stop override every normal transition.
        if (any_error || stop_i) begin
            wr_state_next_s = WR_IDLE;
        end
    end

    // Counter only advances on an accepted non-final beat; any return to
    // idle clears it, so it cannot wrap.
    always_comb begin
        cnt_next = cnt_reg;
        if (wr_state_next_s == WR_IDLE) begin
            cnt_next = 4'd0;
        end else if (beat_accept) begin
            cnt_next = cnt_reg + 4'd2;
        end
    end

    // The counter is always even, so the word pair is {cnt|1, cnt}.
    assign lo_idx = {cnt_next[IDX_W-1:1], 1'b0};
    assign hi_idx = {cnt_next[IDX_W-1:1], 1'b1};

    // Beat data is registered from the next counter value; while ready is
    // low the counter holds, so the presented beat holds too.
    always_comb begin
        beat_next = '0;
        if (wr_state_next_s == WR_GRANTED) begin
            beat_next = {word[hi_idx], word[lo_idx]};
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_state_r             <= WR_IDLE;
            cnt_reg                <= 4'd0;
            addr_reg               <= '0;
            size_reg               <= 4'd0;
            data_reg               <= '0;
            bus.bus_req_o          <= 1'b0;
            bus.bus_write_o        <= 1'b0;
            bus.bus_write_valid_o  <= 1'b0;
            bus.bus_write_data_o   <= '0;
            wr_done_o              <= 1'b0;
            wr_state_error_o       <= 1'b0;
        end else begin
            wr_state_r <= wr_state_next_s;
            cnt_reg    <= cnt_next;
            if (start_ok) begin
                addr_reg <= wr_addr_i;
                size_reg <= wr_size_i;
                data_reg <= data_reg_i;
            end
            // Outputs are registered from the next state so they line up
            // with wr_state_r after the edge.
            bus.bus_req_o         <= (wr_state_next_s == WR_ASK) ||
                                     (wr_state_next_s == WR_GRANTED);
            bus.bus_write_o       <= (wr_state_next_s == WR_ASK) ||
                                     (wr_state_next_s == WR_GRANTED);
            bus.bus_write_valid_o <= (wr_state_next_s == WR_GRANTED);
            bus.bus_write_data_o  <= beat_next;
            wr_done_o             <= last_beat && !stop_i && !any_error;
            wr_state_error_o      <= (wr_state_next_s == WR_UNUSED);
        end
    end

    assign bus.bus_addr_o = addr_reg;
    assign bus.bus_size_o = size_reg;

endmodule

// File: tb/tb_ip_codma_write_machine.sv
module tb_ip_codma_write_machine;
    import ip_codma_pkg::*;

    logic           clk_i;
    logic           reset_n_i;
    logic           need_write_i;
    logic           stop_i;
    logic           dma_error_i;
    logic [31:0]    wr_addr_i;
    logic [3:0]     wr_size_i;
    logic [255:0]   data_reg_i;
    logic           wr_done_o;
    logic           wr_state_error_o;
    write_state_t   wr_state_r;
    write_state_t   wr_state_next_s;

    int n_tests = 0;
    int n_fail  = 0;

    ip_codma_write_machine_if #(.ADDR_W(32), .DATA_W(64)) bus_if ();

    ip_codma_write_machine #(.ADDR_W(32), .DATA_W(64), .WORDS(8)) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .need_write_i     (need_write_i),
        .stop_i           (stop_i),
        .dma_error_i      (dma_error_i),
        .wr_addr_i        (wr_addr_i),
        .wr_size_i        (wr_size_i),
        .data_reg_i       (data_reg_i),
        .bus              (bus_if),
        .wr_done_o        (wr_done_o),
        .wr_state_error_o (wr_state_error_o),
        .wr_state_r       (wr_state_r),
        .wr_state_next_s  (wr_state_next_s)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         need;
        logic         stop;
        logic         grant;
        logic         ready;
        logic [3:0]   size;
        logic [31:0]  addr;
        write_state_t e_state;
        logic         e_req;
        logic         e_valid;
        logic         e_done;
        logic         e_err;
        logic [63:0]  e_data;
        logic [31:0]  e_addr;
        logic [3:0]   e_size;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mkv(input logic need, input logic stop, input logic grant,
                                 input logic ready, input logic [3:0] size,
                                 input logic [31:0] addr, input write_state_t e_state,
                                 input logic e_req, input logic e_valid, input logic e_done,
                                 input logic e_err, input logic [63:0] e_data,
                                 input logic [31:0] e_addr, input logic [3:0] e_size);
        vec_t v;
        v.need = need;   v.stop = stop;   v.grant = grant; v.ready = ready;
        v.size = size;   v.addr = addr;   v.e_state = e_state;
        v.e_req = e_req; v.e_valid = e_valid; v.e_done = e_done; v.e_err = e_err;
        v.e_data = e_data; v.e_addr = e_addr; v.e_size = e_size;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic fill_data(input logic [31:0] base);
        for (int i = 0; i < 8; i++) data_reg_i[i*32 +: 32] = base + 32'(i);
    endtask

    function automatic logic [63:0] beat_of(input logic [31:0] base, input int k);
        return {base + 32'(2*k + 1), base + 32'(2*k)};
    endfunction

    task automatic clear_inputs();
        need_write_i = 1'b0; stop_i = 1'b0; dma_error_i = 1'b0;
        bus_if.bus_grant_i = 1'b0; bus_if.bus_write_ready_i = 1'b0;
        bus_if.bus_error_i = 1'b0; wr_addr_i = '0; wr_size_i = '0;
    endtask

    function automatic logic [127:0] all_outputs();
        return {17'd0, wr_state_r, wr_state_next_s, bus_if.bus_req_o, bus_if.bus_write_o,
                bus_if.bus_write_valid_o, wr_done_o, wr_state_error_o,
                bus_if.bus_write_data_o, bus_if.bus_addr_o, bus_if.bus_size_o};
    endfunction

    initial begin
        logic [106:0] obs;
        logic [106:0] exp;
        logic         prev_ready;
        logic         prev_valid;
        logic         accepted;
        logic         burst_done;
        int           k;

        clear_inputs();
        data_reg_i = '0;
        reset_n_i  = 1'b0;

        // Table: single-beat write, illegal size, stop together with request.
        vecs[0] = mkv(1,0,0,0,4'd3,32'h1000,     WR_ASK,    1,0,0,0,64'h0,                  32'h1000,4'd3);
        vecs[1] = mkv(0,0,0,0,4'd0,32'h0,        WR_ASK,    1,0,0,0,64'h0,                  32'h1000,4'd3);
        vecs[2] = mkv(0,0,0,0,4'd0,32'h0,        WR_ASK,    1,0,0,0,64'h0,                  32'h1000,4'd3);
        vecs[3] = mkv(0,0,1,1,4'd0,32'h0,        WR_GRANTED,1,1,0,0,64'h00000022_00000011,  32'h1000,4'd3);
        vecs[4] = mkv(0,0,1,1,4'd0,32'h0,        WR_IDLE,   0,0,1,0,64'h0,                  32'h1000,4'd3);
        vecs[5] = mkv(0,0,0,0,4'd0,32'h0,        WR_IDLE,   0,0,0,0,64'h0,                  32'h1000,4'd3);
        vecs[6] = mkv(1,0,0,0,4'd5,32'hDEAD0000, WR_UNUSED, 0,0,0,1,64'h0,                  32'h1000,4'd3);
        vecs[7] = mkv(0,0,0,0,4'd0,32'h0,        WR_IDLE,   0,0,0,0,64'h0,                  32'h1000,4'd3);
        vecs[8] = mkv(1,1,0,0,4'd3,32'h5555,     WR_IDLE,   0,0,0,0,64'h0,                  32'h1000,4'd3);
        vecs[9] = mkv(0,0,0,0,4'd0,32'h0,        WR_IDLE,   0,0,0,0,64'h0,                  32'h1000,4'd3);

        repeat (3) @(posedge clk_i);
        #1;
        check("reset_state", all_outputs(), 128'd0);
        reset_n_i = 1'b1;

        // Words 0x11, 0x22, ... 0x88.
        for (int i = 0; i < 8; i++) data_reg_i[i*32 +: 32] = 32'h11 * 32'(i + 1);

        for (int i = 0; i < 10; i++) begin
            need_write_i = vecs[i].need;
            stop_i       = vecs[i].stop;
            bus_if.bus_grant_i       = vecs[i].grant;
            bus_if.bus_write_ready_i = vecs[i].ready;
            wr_size_i    = vecs[i].size;
            wr_addr_i    = vecs[i].addr;
            step();
            obs = {wr_state_r, bus_if.bus_req_o, bus_if.bus_write_o, bus_if.bus_write_valid_o,
                   wr_done_o, wr_state_error_o, bus_if.bus_write_data_o,
                   bus_if.bus_addr_o, bus_if.bus_size_o};
            exp = {vecs[i].e_state, vecs[i].e_req, vecs[i].e_req, vecs[i].e_valid,
                   vecs[i].e_done, vecs[i].e_err, vecs[i].e_data, vecs[i].e_addr, vecs[i].e_size};
            check($sformatf("vec%0d", i), 128'(obs), 128'(exp));
        end
        clear_inputs();

        // Eight-word burst, ready low every other cycle, data changed after latch.
        fill_data(32'hA0000000);
        need_write_i = 1'b1; wr_size_i = 4'd9; wr_addr_i = 32'h2000;
        step();
        check("burst_ask", 128'(wr_state_r), 128'(WR_ASK));
        need_write_i = 1'b0;
        data_reg_i   = '1;
        bus_if.bus_grant_i = 1'b1;
        step();
        check("burst_granted", 128'(wr_state_r), 128'(WR_GRANTED));
        k = 0;
        burst_done = 1'b0;
        for (int c = 0; c < 20 && !burst_done; c++) begin
            if (bus_if.bus_write_valid_o)
                check($sformatf("burst_beat%0d_c%0d", k, c), 128'(bus_if.bus_write_data_o),
                      128'(beat_of(32'hA0000000, k)));
            prev_valid = bus_if.bus_write_valid_o;
            prev_ready = c[0];
            bus_if.bus_write_ready_i = prev_ready;
            step();
            accepted = prev_valid && prev_ready;
            if (accepted) k++;
            check($sformatf("burst_done_c%0d", c), 128'(wr_done_o), 128'(accepted && k == 4));
            if (k == 4) begin
                check("burst_idle", 128'(wr_state_r), 128'(WR_IDLE));
                burst_done = 1'b1;
            end
        end
        if (!burst_done) check("burst_timeout", 128'(k), 128'd4);
        clear_inputs();
        step();

        // Stop after the first beat of a size-8 burst, then a fresh size-3 write.
        fill_data(32'hC0000000);
        need_write_i = 1'b1; wr_size_i = 4'd8; wr_addr_i = 32'h3000;
        step();
        need_write_i = 1'b0;
        bus_if.bus_grant_i = 1'b1; bus_if.bus_write_ready_i = 1'b1;
        step();
        check("stop_beat0", 128'(bus_if.bus_write_data_o), 128'(beat_of(32'hC0000000, 0)));
        step();
        check("stop_beat1", 128'(bus_if.bus_write_data_o), 128'(beat_of(32'hC0000000, 1)));
        stop_i = 1'b1; bus_if.bus_write_ready_i = 1'b0;
        #1;
        check("stop_next_s", 128'(wr_state_next_s), 128'(WR_IDLE));
        step();
        check("stop_idle", 128'({wr_state_r, wr_done_o, bus_if.bus_write_valid_o}),
              128'({WR_IDLE, 1'b0, 1'b0}));
        stop_i = 1'b0; bus_if.bus_grant_i = 1'b0;
        need_write_i = 1'b1; wr_size_i = 4'd3; wr_addr_i = 32'h4000;
        step();
        check("restart_ask", 128'({wr_state_r, bus_if.bus_addr_o}), 128'({WR_ASK, 32'h4000}));
        need_write_i = 1'b0; bus_if.bus_grant_i = 1'b1;
        step();
        check("restart_beat0", 128'(bus_if.bus_write_data_o), 128'(beat_of(32'hC0000000, 0)));
        bus_if.bus_write_ready_i = 1'b1;
        step();
        check("restart_done", 128'({wr_state_r, wr_done_o}), 128'({WR_IDLE, 1'b1}));
        clear_inputs();
        step();

        // Bus error in the same cycle as the final beat acceptance.
        need_write_i = 1'b1; wr_size_i = 4'd3; wr_addr_i = 32'h5000;
        step();
        need_write_i = 1'b0; bus_if.bus_grant_i = 1'b1;
        step();
        bus_if.bus_write_ready_i = 1'b1; bus_if.bus_error_i = 1'b1;
        step();
        check("err_final", 128'({wr_state_r, wr_done_o}), 128'({WR_IDLE, 1'b0}));
        clear_inputs();
        step();
        check("err_after", 128'({wr_state_r, wr_done_o}), 128'({WR_IDLE, 1'b0}));

        // DMA error while waiting for grant.
        need_write_i = 1'b1; wr_size_i = 4'd9; wr_addr_i = 32'h6000;
        step();
        need_write_i = 1'b0; dma_error_i = 1'b1;
        step();
        check("dma_err_ask", 128'({wr_state_r, bus_if.bus_req_o}), 128'({WR_IDLE, 1'b0}));
        clear_inputs();

        // Asynchronous reset while in WR_GRANTED.
        need_write_i = 1'b1; wr_size_i = 4'd3; wr_addr_i = 32'h7000;
        step();
        need_write_i = 1'b0; bus_if.bus_grant_i = 1'b1;
        step();
        check("pre_reset_valid", 128'({wr_state_r, bus_if.bus_write_valid_o}),
              128'({WR_GRANTED, 1'b1}));
        #3;
        reset_n_i = 1'b0;
        #1;
        check("async_reset", all_outputs(), 128'd0);
        clear_inputs();
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
        step();
        check("post_reset_idle", 128'(wr_state_r), 128'(WR_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
